// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - RV32I opcode constants, packed opcode field and queue entry layout
package instr_queue_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // 17-bit opcode as presented on out_opcode: {funct7, funct3, opcode}
  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } opfield_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    opfield_t    op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } iq_entry_t;

  function automatic opfield_t pack_opfield(input logic [31:0] instr);
    opfield_t f;
    f.funct7 = instr[31:25];
    f.funct3 = instr[14:12];
    f.opcode = instr[6:0];
    return f;
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/instr_queue_rv_imm_decode.sv
// rtl/instr_queue_rv_imm_decode.sv - combinational RV32I field and immediate decode (module rv_imm_decode)
module rv_imm_decode
  import instr_queue_pkg::*;
(
  input  logic [31:0] instr,
  output opfield_t    op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);

  assign op  = pack_opfield(instr);
  assign rd  = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_JALR: imm = sext12(instr[31:20]);
      OPC_OPIMM: begin
        // shift amounts are unsigned; funct7 bits above shamt must not leak into imm
        if (instr[14:12] == F3_SLL || instr[14:12] == F3_SRX)
          imm = {27'b0, instr[24:20]};
        else
          imm = sext12(instr[31:20]);
      end
      OPC_STORE:  imm = sext12({instr[31:25], instr[11:7]});
      OPC_BRANCH: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
      OPC_JAL:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_OP:     imm = '0;
      default:    imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - decoded instruction FIFO between icache and dispatch; IQ_PERF_EN adds stall_cnt_out
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int IQ_DEPTH = 16,
  parameter int IQ_AW    = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [16:0]       out_opcode,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [31:0]       out_imm,
  output logic [IQ_AW:0]    count_out
`ifdef IQ_PERF_EN
  ,
  output logic [31:0]       stall_cnt_out
`endif
);

  localparam logic [IQ_AW:0]   FULL_CNT = (IQ_AW+1)'(IQ_DEPTH);
  localparam logic [IQ_AW-1:0] PTR_ONE  = IQ_AW'(1);
  localparam logic [IQ_AW:0]   CNT_ONE  = (IQ_AW+1)'(1);

  iq_entry_t        mem [IQ_DEPTH];
  iq_entry_t        wr_entry;
  iq_entry_t        head_entry;
  logic [IQ_AW-1:0] head;
  logic [IQ_AW-1:0] tail;
  logic [IQ_AW:0]   count;
  logic             full;
  logic             push;
  logic             pop;

  opfield_t    dec_op;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;

  rv_imm_decode u_dec (
    .instr (in_instr),
    .op    (dec_op),
    .rd    (dec_rd),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .imm   (dec_imm)
  );

  // full blocks the push even if the head pops this cycle: no same-cycle refill
  assign full      = (count == FULL_CNT);
  assign in_ready  = !full && !flush_in;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && rdy_in;
  assign pop       = out_valid && out_ready && rdy_in && !flush_in;

  always_comb begin
    wr_entry       = '0;
    wr_entry.instr = in_instr;
    wr_entry.pc    = in_pc;
    wr_entry.op    = dec_op;
    wr_entry.rd    = dec_rd;
    wr_entry.rs1   = dec_rs1;
    wr_entry.rs2   = dec_rs2;
    wr_entry.imm   = dec_imm;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // entry payload is not reset; validity is tracked solely by count
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) mem[tail] <= wr_entry;
  end

  assign head_entry = mem[head];
  assign out_instr  = head_entry.instr;
  assign out_pc     = head_entry.pc;
  assign out_opcode = head_entry.op;
  assign out_rd     = head_entry.rd;
  assign out_rs1    = head_entry.rs1;
  assign out_rs2    = head_entry.rs2;
  assign out_imm    = head_entry.imm;
  assign count_out  = count;

`ifdef IQ_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in)
      stall_cnt <= '0;
    else if (rdy_in && in_valid && !in_ready && !flush_in)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cnt_out = stall_cnt;
`endif

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 16: number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter IQ_AW, default 4: pointer width; SHALL equal log2(IQ_DEPTH).
REQ-003 Ports SHALL be exactly:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global enable; low freezes all state.
- flush_in  input  1  ROB mispredict clear.
- in_valid  input  1  icache presents an instruction.
- in_instr  input  32  raw instruction.
- in_pc  input  32  instruction PC.
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  dispatch/ROB accepts the head.
- out_instr  output  32  head raw instruction.
- out_pc  output  32  head PC.
- out_opcode  output  17  {instr[31:25], instr[14:12], instr[6:0]}.
- out_rd, out_rs1, out_rs2  output  5 each  instr[11:7], [19:15], [24:20].
- out_imm  output  32  decoded immediate.
- count_out  output  IQ_AW+1  occupied entries.

Function
REQ-004 Storage SHALL be a circular buffer: head pointer, tail pointer, and occupancy counter; pointers wrap modulo IQ_DEPTH.
REQ-005 in_ready SHALL be (count < IQ_DEPTH) && !flush_in; a push occurs when in_valid && in_ready && rdy_in.
REQ-006 out_valid SHALL be (count != 0); a pop occurs when out_valid && out_ready && rdy_in && !flush_in.
REQ-007 All out_* fields SHALL be driven combinationally from the head entry; they are don't-care when out_valid is 0.
REQ-008 Push and pop in the same cycle SHALL both take effect, and count SHALL remain unchanged.
REQ-009 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; no same-cycle refill.
REQ-010 Decode SHALL happen at push time and store opcode, rd, rs1, rs2 and imm per entry.
REQ-011 Immediate rules, sign-extended from instr[31] unless stated:
- I-type (0000011, 0010011, 1100111): instr[31:20].
- Shifts (0010011 with funct3 001 or 101): zero-extended instr[24:20].
- S-type (0100011): {instr[31:25], instr[11:7]}.
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type (0110111, 0010111): {instr[31:12], 12'b0}.
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Any other opcode: 0.
REQ-012 flush_in && rdy_in SHALL empty the queue in one cycle (head = tail = count = 0) and discard any same-cycle push or pop.
REQ-013 With rdy_in = 0, pointers, count and entries SHALL hold, and no push or pop SHALL occur.
REQ-014 Latency: an entry pushed at edge N SHALL be visible at the head after edge N if the queue was empty, and SHALL be popped in FIFO order.

Reset
REQ-015 rst_in SHALL have priority over rdy_in and flush_in.
REQ-016 After reset: head = tail = count = 0, out_valid = 0, in_ready = 1, count_out = 0; entry contents need not be reset.
REQ-017 Reset mid-operation SHALL discard all entries, with no pop reported in that cycle.

Configuration
REQ-018 With macro IQ_PERF_EN defined: extra output stall_cnt_out (32 bits) SHALL count cycles where rdy_in && in_valid && !in_ready && !flush_in; it resets to 0 and wraps at 2^32.
REQ-019 Without IQ_PERF_EN, the port and the counter SHALL be absent, with all other behaviour identical.

Structure
REQ-020 A shared package SHALL hold the RV32I opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP) and the 17-bit opcode field layout.
REQ-021 Immediate/field decode SHALL be a combinational sub-module, rv_imm_decode; storage and pointers live in instr_queue.

Verification
REQ-022 Push 16 instructions with out_ready = 0 -> count_out = 16 and in_ready = 0; 17th in_valid held -> not accepted.
REQ-023 Full queue, in_valid = 1 and out_ready = 1 for one cycle -> pop only, count 15; next cycle push accepted.
REQ-024 Push 0xFFF00093 (addi x1,x0,-1) -> out_imm 0xFFFFFFFF, out_rd 1, out_opcode[6:0] 0010011.
REQ-025 Push 0xFE000EE3 (beq, offset -4) -> out_imm 0xFFFFFFFC; push 0x800000EF (jal) -> out_imm 0xFFF00000.
REQ-026 Five entries queued, flush_in with in_valid = 1 -> next cycle count_out = 0 and out_valid = 0; wrap test of 40 pushes/pops preserves PC order.
REQ-027 rdy_in = 0 for 3 cycles during push/pop -> count and head unchanged; with IQ_PERF_EN, 4 full-stall cycles -> stall_cnt_out = 4.
